// File: rtl/spawn_sequencer.sv
// Multi-level obstacle spawn sequencer: game-tick timing, per-level object
// release, collision restart and level/banner/done flags for the display mux.
module spawn_sequencer #(
  parameter int unsigned TICK_CYCLES = 50_000_000,
  parameter int unsigned N_OBJ       = 10,
  parameter int unsigned N_COL       = 2,
  parameter int unsigned N_LEVELS    = 2,
  parameter int unsigned START_DELAY = 1,
  parameter int unsigned SPAWN_GAP   = 2,
  parameter int unsigned INTER_DELAY = 3,
  parameter logic [7:0]  KEY_START   = 8'd40,
  localparam int unsigned LW = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic [7:0]       keycode_i,
  input  logic [N_COL-1:0] collision_i,
  input  logic [N_OBJ-1:0] obj_cleared_i,
  output logic [N_OBJ-1:0] obj_ready_o,
  output logic [LW-1:0]    level_o,
  output logic             title_o,
  output logic             banner_o,
  output logic             game_done_o,
  output logic [9:0]       seconds_o,
  output logic [7:0]       deaths_o
);

  localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned IW = $clog2(N_OBJ + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_CYCLES - 1);
  localparam logic [N_OBJ-1:0] ONE = N_OBJ'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INTRO,
    S_SPAWN,
    S_HOLD,
    S_INTER,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [9:0]       sec_q, sec_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic [7:0]       deaths_q, deaths_d;
  logic [N_OBJ-1:0] rdy_q, rdy_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             title_q, banner_q, done_q;

  logic             counting;
  logic             tick;
  logic             hit;
  logic             restart;
  logic             entry;
  logic [10:0]      sec_p1;
  logic [N_OBJ-1:0] left;
  int               gap;

  assign counting = (state_q != S_IDLE) && (state_q != S_DONE);
  assign tick     = counting && (cnt_q == CNT_MAX);
  assign hit      = |collision_i;
  assign restart  = hit && ((state_q == S_SPAWN) || (state_q == S_HOLD));
  assign sec_p1   = {1'b0, sec_q} + 11'd1;
  assign left     = rdy_q & ~obj_cleared_i;

  always_comb begin
    gap = int'(SPAWN_GAP) - int'(lvl_q);
    if (gap < 1) gap = 1;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sec_d    = sec_q;
    lvl_d    = lvl_q;
    deaths_d = deaths_q;
    rdy_d    = left;
    idx_d    = idx_q;
    entry    = 1'b0;

    if (counting) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      if (tick && (sec_q != 10'h3FF)) begin
        sec_d = sec_q + 10'd1;
      end
    end

    if (restart) begin
      state_d  = S_INTRO;
      rdy_d    = '0;
      idx_d    = '0;
      entry    = 1'b1;
      if (deaths_q != 8'hFF) begin
        deaths_d = deaths_q + 8'd1;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (run_i || (keycode_i == KEY_START)) begin
            state_d = S_INTRO;
            entry   = 1'b1;
          end
        end
        S_INTRO: begin
          if ((START_DELAY == 0) ||
              (tick && (sec_p1 == 11'(START_DELAY)))) begin
            state_d = (N_OBJ == 1) ? S_HOLD : S_SPAWN;
            rdy_d   = left | ONE;
            idx_d   = IW'(1);
            entry   = 1'b1;
          end
        end
        S_SPAWN: begin
          if (tick && (sec_p1 == 11'(gap))) begin
            rdy_d = left | (ONE << idx_q);
            idx_d = idx_q + IW'(1);
            sec_d = '0;
            if (idx_q + IW'(1) == IW'(N_OBJ)) begin
              state_d = S_HOLD;
              entry   = 1'b1;
            end
          end
        end
        S_HOLD: begin
          // Clears seen this cycle count toward completing the level.
          if (left == '0) begin
            entry = 1'b1;
            if (int'(lvl_q) < int'(N_LEVELS) - 1) begin
              state_d = S_INTER;
              lvl_d   = lvl_q + LW'(1);
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_INTER: begin
          if ((INTER_DELAY == 0) ||
              (tick && (sec_p1 == 11'(INTER_DELAY)))) begin
            state_d = S_INTRO;
            entry   = 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    if (entry) begin
      cnt_d = '0;
      sec_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sec_q    <= '0;
      lvl_q    <= '0;
      deaths_q <= '0;
      rdy_q    <= '0;
      idx_q    <= '0;
      title_q  <= 1'b1;
      banner_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sec_q    <= sec_d;
      lvl_q    <= lvl_d;
      deaths_q <= deaths_d;
      rdy_q    <= rdy_d;
      idx_q    <= idx_d;
      title_q  <= (state_d == S_IDLE);
      banner_q <= (state_d == S_INTER);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign obj_ready_o = rdy_q;
  assign level_o     = lvl_q;
  assign title_o     = title_q;
  assign banner_o    = banner_q;
  assign game_done_o = done_q;
  assign seconds_o   = sec_q;
  assign deaths_o    = deaths_q;

endmodule

// File: tb/tb_spawn_sequencer.sv
// Scoreboard bench for spawn_sequencer: a cycle-count reference model
// predicts every output cycle; a monitor pops and compares.
module tb_spawn_sequencer;

  localparam int TK    = 4;
  localparam int NOBJ  = 3;
  localparam int NLEV  = 2;
  localparam int GAP0  = 2;
  localparam int SDLY  = 1;
  localparam int IDLY  = 3;

  localparam int P_IDLE  = 0;
  localparam int P_INTRO = 1;
  localparam int P_SPAWN = 2;
  localparam int P_HOLD  = 3;
  localparam int P_INTER = 4;
  localparam int P_DONE  = 5;

  typedef struct packed {
    logic [2:0] rdy;
    logic       lvl;
    logic       title;
    logic       banner;
    logic       done;
    logic [9:0] sec;
    logic [7:0] deaths;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       run_i = 1'b0;
  logic [7:0] keycode_i = 8'h00;
  logic [1:0] collision_i = 2'b00;
  logic [2:0] obj_cleared_i = 3'b000;
  logic [2:0] obj_ready_o;
  logic [0:0] level_o;
  logic       title_o, banner_o, game_done_o;
  logic [9:0] seconds_o;
  logic [7:0] deaths_o;

  spawn_sequencer #(
    .TICK_CYCLES(TK), .N_OBJ(NOBJ), .N_COL(2), .N_LEVELS(NLEV),
    .START_DELAY(SDLY), .SPAWN_GAP(GAP0), .INTER_DELAY(IDLY),
    .KEY_START(8'd40)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .run_i(run_i), .keycode_i(keycode_i),
    .collision_i(collision_i), .obj_cleared_i(obj_cleared_i),
    .obj_ready_o(obj_ready_o), .level_o(level_o), .title_o(title_o),
    .banner_o(banner_o), .game_done_o(game_done_o),
    .seconds_o(seconds_o), .deaths_o(deaths_o)
  );

  always #5 clk = ~clk;

  obs_t expq[$];
  int   nchk = 0;
  int   npass = 0;
  bit   active = 1'b0;
  bit   seen_done = 1'b0;

  // reference model: cycles elapsed since phase entry / last spawn
  int         m_ph, m_cyc, m_lvl, m_deaths, m_nsp;
  logic [2:0] m_rdy;

  function automatic obs_t model_out();
    obs_t o;
    int s;
    s = m_cyc / TK;
    if (s > 1023) s = 1023;
    o.rdy    = m_rdy;
    o.lvl    = 1'(m_lvl);
    o.title  = (m_ph == P_IDLE);
    o.banner = (m_ph == P_INTER);
    o.done   = (m_ph == P_DONE);
    o.sec    = 10'(s);
    o.deaths = 8'(m_deaths);
    return o;
  endfunction

  task automatic enter(input int p);
    m_ph  = p;
    m_cyc = 0;
  endtask

  task automatic model(input logic r, input logic [7:0] k,
                       input logic [1:0] c, input logic [2:0] cl,
                       input logic rs);
    logic       hit;
    logic [2:0] left;
    int         g;
    if (rs) begin
      m_ph = P_IDLE; m_cyc = 0; m_lvl = 0;
      m_deaths = 0; m_rdy = 3'b000; m_nsp = 0;
      return;
    end
    hit   = |c;
    left  = m_rdy & ~cl;
    m_rdy = left;
    g     = (GAP0 - m_lvl < 1) ? 1 : GAP0 - m_lvl;
    if (m_ph != P_IDLE && m_ph != P_DONE) m_cyc++;
    if (hit && (m_ph == P_SPAWN || m_ph == P_HOLD)) begin
      m_rdy = 3'b000;
      m_nsp = 0;
      if (m_deaths < 255) m_deaths++;
      enter(P_INTRO);
    end else begin
      case (m_ph)
        P_IDLE:  if (r || k == 8'd40) enter(P_INTRO);
        P_INTRO: if (m_cyc == SDLY * TK) begin
          m_rdy = 3'b001;
          m_nsp = 1;
          enter(P_SPAWN);
        end
        P_SPAWN: if (m_cyc == g * TK) begin
          m_rdy[m_nsp] = 1'b1;
          m_nsp++;
          m_cyc = 0;
          if (m_nsp == NOBJ) enter(P_HOLD);
        end
        P_HOLD: if (left == 3'b000) begin
          if (m_lvl < NLEV - 1) begin
            m_lvl++;
            enter(P_INTER);
          end else begin
            enter(P_DONE);
          end
        end
        P_INTER: if (m_cyc == IDLY * TK) enter(P_INTRO);
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic [7:0] k,
                      input logic [1:0] c, input logic [2:0] cl,
                      input logic rs);
    @(negedge clk);
    run_i = r;
    keycode_i = k;
    collision_i = c;
    obj_cleared_i = cl;
    rst_i = rs;
    model(r, k, c, cl, rs);
    expq.push_back(model_out());
    active = 1'b1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 2'b00, 3'b000, 1'b0);
  endtask

  task automatic run_until(input int ph, input int maxc, input string tag);
    int n;
    n = 0;
    while (m_ph != ph && n < maxc) begin
      idle();
      n++;
    end
    if (m_ph != ph) begin
      nchk++;
      $display("FAIL %s: phase budget expired, phase=%0d want=%0d",
               tag, m_ph, ph);
    end
  endtask

  task automatic clear_hold(input string tag);
    run_until(P_HOLD, 200, tag);
    step(1'b0, 8'h00, 2'b00, 3'b111, 1'b0);
  endtask

  // monitor: every cycle the DUT presents a full output word
  initial begin
    obs_t got, exp;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0) begin
        exp = expq.pop_front();
        got = '{obj_ready_o, level_o, title_o, banner_o,
                game_done_o, seconds_o, deaths_o};
        if (game_done_o) seen_done = 1'b1;
        nchk++;
        if (got === exp) begin
          npass++;
        end else begin
          $display("FAIL outputs t=%0t got rdy=%b lvl=%0d ttl=%b ban=%b dn=%b sec=%0d dth=%0d required rdy=%b lvl=%0d ttl=%b ban=%b dn=%b sec=%0d dth=%0d",
                   $time, got.rdy, got.lvl, got.title, got.banner,
                   got.done, got.sec, got.deaths, exp.rdy, exp.lvl,
                   exp.title, exp.banner, exp.done, exp.sec, exp.deaths);
        end
      end else if (active) begin
        nchk++;
        $display("FAIL scoreboard: empty queue at t=%0t got 0 entries required 1",
                 $time);
      end
    end
  end

  initial begin
    logic       r, rs;
    logic [7:0] k;
    logic [1:0] c;
    logic [2:0] cl;

    step(1'b0, 8'h00, 2'b00, 3'b000, 1'b1);
    step(1'b0, 8'h00, 2'b00, 3'b000, 1'b1);
    repeat (3) idle();

    // reset mid-spawn
    step(1'b1, 8'h00, 2'b00, 3'b000, 1'b0);
    run_until(P_SPAWN, 50, "to_spawn");
    idle();
    step(1'b0, 8'h00, 2'b00, 3'b000, 1'b1);
    idle();

    // keycode start, full level 0, banner, level 1 spawn pacing
    step(1'b0, 8'd40, 2'b00, 3'b000, 1'b0);
    run_until(P_HOLD, 100, "l0_hold");
    repeat (3) idle();
    step(1'b0, 8'h00, 2'b00, 3'b111, 1'b0);
    run_until(P_SPAWN, 100, "l1_spawn");

    // collision with two objects live, held for several cycles
    while (m_rdy != 3'b011 && m_ph == P_SPAWN) idle();
    step(1'b0, 8'h00, 2'b10, 3'b000, 1'b0);
    step(1'b0, 8'h00, 2'b10, 3'b000, 1'b0);
    step(1'b0, 8'h00, 2'b10, 3'b000, 1'b0);

    // collision together with the final clear
    run_until(P_HOLD, 100, "l1_hold");
    step(1'b0, 8'h00, 2'b01, 3'b111, 1'b0);
    clear_hold("l1_done");
    step(1'b1, 8'h00, 2'b11, 3'b000, 1'b0);
    step(1'b0, 8'd40, 2'b01, 3'b101, 1'b0);
    repeat (3) idle();
    step(1'b0, 8'h00, 2'b00, 3'b000, 1'b1);
    idle();

    // seconds saturation while holding
    step(1'b1, 8'h00, 2'b00, 3'b000, 1'b0);
    run_until(P_HOLD, 100, "sat_hold");
    repeat (4200) idle();

    // deaths saturation
    for (int i = 0; i < 260; i++) begin
      if (m_ph != P_SPAWN && m_ph != P_HOLD)
        run_until(P_SPAWN, 50, "death_loop");
      step(1'b0, 8'h00, 2'b01, 3'b000, 1'b0);
    end
    clear_hold("sat_l0");
    clear_hold("sat_l1");
    repeat (2) idle();
    step(1'b0, 8'h00, 2'b00, 3'b000, 1'b1);

    // randomized play
    for (int i = 0; i < 6000; i++) begin
      r  = ($urandom % 40 == 0);
      k  = ($urandom % 50 == 0) ? 8'd40 : 8'($urandom);
      c  = ($urandom % 70 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cl = {($urandom % 6 == 0), ($urandom % 6 == 0), ($urandom % 6 == 0)};
      rs = ($urandom % 1500 == 0);
      step(r, k, c, cl, rs);
    end

    @(posedge clk);
    #3;
    active = 1'b0;
    nchk++;
    if (expq.size() == 0) npass++;
    else $display("FAIL drain: got %0d pending required 0", expq.size());
    nchk++;
    if (seen_done) npass++;
    else $display("FAIL game_done_seen: got 0 required 1");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
